// File: rtl/mult_ctrl.sv
// Sequencing front-end for a shift-add multiplier: operand handshake, load/run control, product capture, hang timeout.
// Define MULT_CTRL_SIGNED_EN to accept two's-complement operands (magnitudes to the multiplier, sign fixed up on capture).
module mult_ctrl #(
  parameter int WIDTH       = 16,
  parameter int LOAD_CYCLES = 1,
  parameter int TIMEOUT     = 40
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  output logic [WIDTH-1:0]     mul_a,
  output logic [WIDTH-1:0]     mul_b,
  output logic                 mul_start_n,
  input  logic                 mul_ready,
  input  logic [2*WIDTH-1:0]   mul_result,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_result,
  output logic                 busy,
  input  logic                 err_clr,
  output logic                 timeout_err,
  output logic [1:0]           dbg_state
);

  localparam int PW = 2 * WIDTH;
  localparam int LW = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [LW-1:0] LOAD_LAST = LW'(LOAD_CYCLES - 1);
  localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_HOLD} state_t;

  state_t          state;
  logic [LW-1:0]   load_cnt;
  logic [TW-1:0]   wait_cnt;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [PW-1:0]    product;

  // Both handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // valid never depends combinationally on ready, and a raised out_valid holds with stable data until taken.
  assign in_ready  = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign dbg_state = state;

`ifdef MULT_CTRL_SIGNED_EN
  logic neg_q;

  always_comb begin
    op_a    = in_a[WIDTH-1] ? (~in_a + WIDTH'(1)) : in_a;
    op_b    = in_b[WIDTH-1] ? (~in_b + WIDTH'(1)) : in_b;
    product = neg_q ? (~mul_result + PW'(1)) : mul_result;
  end
`else
  always_comb begin
    op_a    = in_a;
    op_b    = in_b;
    product = mul_result;
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      mul_a       <= '0;
      mul_b       <= '0;
      mul_start_n <= 1'b0;
      out_valid   <= 1'b0;
      out_result  <= '0;
      timeout_err <= 1'b0;
      load_cnt    <= '0;
      wait_cnt    <= '0;
`ifdef MULT_CTRL_SIGNED_EN
      neg_q       <= 1'b0;
`endif
    end else begin
      // A timeout in the RUN branch below overrides this clear on the same edge.
      if (err_clr) timeout_err <= 1'b0;
      case (state)
        S_IDLE: begin
          mul_start_n <= 1'b0;
          if (in_valid) begin
            mul_a    <= op_a;
            mul_b    <= op_b;
`ifdef MULT_CTRL_SIGNED_EN
            neg_q    <= in_a[WIDTH-1] ^ in_b[WIDTH-1];
`endif
            load_cnt <= '0;
            state    <= S_LOAD;
          end
        end
        S_LOAD: begin
          mul_start_n <= 1'b0;
          if (load_cnt == LOAD_LAST) begin
            mul_start_n <= 1'b1;
            wait_cnt    <= '0;
            state       <= S_RUN;
          end else begin
            load_cnt <= load_cnt + LW'(1);
          end
        end
        S_RUN: begin
          if (mul_ready) begin
            out_result <= product;
            out_valid  <= 1'b1;
            state      <= S_HOLD;
          end else if (wait_cnt == WAIT_LAST) begin
            timeout_err <= 1'b1;
            mul_start_n <= 1'b0;
            state       <= S_IDLE;
          end else begin
            wait_cnt <= wait_cnt + TW'(1);
          end
        end
        S_HOLD: begin
          if (out_ready) begin
            out_valid   <= 1'b0;
            mul_start_n <= 1'b0;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/mult_ctrl.md
Name: mult_ctrl

Overview:
Sequencing front-end placed directly upstream of the 16x16 shift-add multiplier on the SDSU bus datapath.
- Accepts operand pairs over a valid/ready handshake and drives the multiplier's operand inputs and active-low load/clear input.
- Waits for the multiplier's ready, captures the 32-bit product, and presents it downstream over a valid/ready handshake.
- Guards against a hung multiplier with a cycle-count timeout.

Parameters:
WIDTH, 16, operand width; product width is 2*WIDTH.
LOAD_CYCLES, 1, cycles mul_start_n is held low with new operands before release (minimum 1).
TIMEOUT, 40, RUN-state cycles allowed before the transaction is abandoned (minimum 2*WIDTH).

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high; clears all state.
in_valid  in  1  operand pair valid.
in_ready  out  1  block can accept operands (high only in IDLE).
in_a  in  WIDTH  operand A.
in_b  in  WIDTH  operand B.
mul_a  out  WIDTH  registered operand to multiplier A.
mul_b  out  WIDTH  registered operand to multiplier B.
mul_start_n  out  1  drives multiplier reset input; low = load/clear, high = run.
mul_ready  in  1  multiplier done.
mul_result  in  2*WIDTH  multiplier product.
out_valid  out  1  product valid.
out_ready  in  1  downstream accepts product.
out_result  out  2*WIDTH  registered product.
busy  out  1  high in any state other than IDLE.
err_clr  in  1  synchronous clear of timeout_err.
timeout_err  out  1  sticky timeout flag.

Behaviour:
- Clock and reset: single clock domain clk. Reset is asynchronous and active-high.
- Reset values: state=IDLE, mul_a=0, mul_b=0, mul_start_n=0, out_valid=0, out_result=0, timeout_err=0, all counters 0. Consequently in_ready=1 and busy=0.
- in_ready and busy are decoded combinationally from state. All other outputs are registered.
- IDLE:
  - mul_start_n=0, keeping the multiplier parked.
  - On in_valid & in_ready at an edge: latch in_a/in_b into mul_a/mul_b, clear the load counter, go to LOAD.
- LOAD:
  - mul_start_n=0.
  - Stay for LOAD_CYCLES edges.
  - On the last edge: set mul_start_n=1, clear the wait counter, go to RUN.
- RUN:
  - mul_start_n=1; the wait counter increments each cycle.
  - mul_ready sampled high: out_result<=mul_result, out_valid<=1, go to HOLD. out_valid is visible the cycle after mul_ready was sampled.
  - Wait counter reaches TIMEOUT-1 with mul_ready low: set timeout_err=1, set mul_start_n=0, go to IDLE. No output is produced and the transaction is dropped.
  - mul_ready and timeout on the same edge: mul_ready wins and the product is delivered.
- HOLD:
  - out_valid=1; out_result is stable; mul_start_n stays 1.
  - On out_valid & out_ready: out_valid<=0, mul_start_n<=0, go to IDLE.
  - Earliest next acceptance is the following edge; there is no back-to-back overlap.
- Operand stability: mul_a/mul_b change only on the IDLE acceptance edge, and are stable through LOAD, RUN and HOLD.
- in_a/in_b changes while not in IDLE are ignored.
- timeout_err:
  - Set only by a timeout.
  - Cleared by reset or err_clr at an edge.
  - A timeout on the same edge as err_clr leaves timeout_err=1 (set wins).
- Reset mid-operation, in any state: immediate return to reset values. A pending out_valid is dropped.
- Nominal latency from acceptance edge to out_valid high: LOAD_CYCLES + multiplier latency (WIDTH+1 cycles) + 1.

Optional Feature:
MULT_CTRL_SIGNED_EN
- Defined:
  - in_a/in_b are two's complement.
  - The acceptance edge latches mul_a=|in_a| and mul_b=|in_b|, computed as unsigned. -2^(WIDTH-1) maps to 2^(WIDTH-1).
  - A sign flag is registered as in_a[MSB]^in_b[MSB].
  - On capture, out_result = sign ? -mul_result : mul_result, in 2*WIDTH two's complement.
- Undefined: operands and product are unsigned and passed straight through; no sign logic is synthesised.

Test Plan:
- Reset, then in_a=3, in_b=5, out_ready=1 -> out_result=0x0000000F; out_valid high for 1 cycle; in_ready returns to 1 the next cycle.
- in_a=0xFFFF, in_b=0xFFFF -> out_result=0xFFFE0001 (unsigned build).
- Product ready with out_ready held 0 for 10 cycles -> out_valid and out_result stable; in_ready=0 and busy=1 throughout; in_valid pulses ignored; transfer completes on the first out_ready=1.
- mul_ready tied 0, TIMEOUT=40 -> timeout_err=1 after 40 RUN cycles; state returns to IDLE; out_valid never asserts; err_clr pulse -> timeout_err=0.
- Assert reset during cycle 8 of RUN -> mul_start_n=0, out_valid=0, in_ready=1 immediately; a following 7*6 transaction yields 0x0000002A.
- MULT_CTRL_SIGNED_EN defined: in_a=0xFFFD (-3), in_b=5 -> 0xFFFFFFF1; in_a=0x8000, in_b=0x8000 -> 0x40000000.
